// File: rtl/mag_comp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_t   : FSM encoding (IDLE=0, SCAN=1, DONE=2)
//   ceilLog2  : ceiling log2, used to size the slice index and ncmp
package mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceilLog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mag_slice_cmp.sv
// Combinational unsigned compare of one SLICE-bit slice.
// Ports:
//   a, b : slice operands
//   gt   : a > b
//   lt   : a < b   (equality is gt == lt == 0)
module mag_slice_cmp #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/mag_comp_serial.sv
// Multi-cycle WIDTH-bit magnitude comparator. Operands are captured on start
// and scanned MSB-first, SLICE bits per clock, stopping at the first slice
// that differs. Signed compares flip the operand MSBs at capture so the
// unsigned slice compare yields two's-complement order.
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   start             : request a compare, accepted only while idle
//   signed_mode       : 1 = two's-complement, 0 = unsigned (sampled with start)
//   A, B              : operands (sampled with start)
//   busy              : high while scanning and in the done cycle
//   done              : one-cycle pulse when results become valid
//   AeqB, AgtB, AltB  : result flags, held until the next accepted start
//   ncmp              : number of slices examined by the last operation
module mag_comp_serial
  import mag_comp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   signed_mode,
  input  logic [WIDTH-1:0]                       A,
  input  logic [WIDTH-1:0]                       B,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   AeqB,
  output logic                                   AgtB,
  output logic                                   AltB,
  output logic [ceilLog2(WIDTH/SLICE+1)-1:0]     ncmp
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = ceilLog2(NSLICE + 1);
  localparam int IW     = (NSLICE > 1) ? ceilLog2(NSLICE) : 1;

  if (WIDTH % SLICE != 0) begin : gWidthCheck
    $error("mag_comp_serial: WIDTH must be a multiple of SLICE");
  end

  state_t           state, stateNext;
  logic [WIDTH-1:0] ra, rb, raNext, rbNext;
  logic [IW-1:0]    idx, idxNext;
  logic             busyNext, doneNext, eqNext, gtNext, ltNext;
  logic [CW-1:0]    ncmpNext;
  logic [SLICE-1:0] sliceA, sliceB;
  logic             sliceGt, sliceLt;

  // Single comparator shared across all slices; idx selects the operands.
  assign sliceA = ra[idx*SLICE +: SLICE];
  assign sliceB = rb[idx*SLICE +: SLICE];

  mag_slice_cmp #(.SLICE(SLICE)) uSliceCmp (
    .a  (sliceA),
    .b  (sliceB),
    .gt (sliceGt),
    .lt (sliceLt)
  );

  always_comb begin
    stateNext = state;
    raNext    = ra;
    rbNext    = rb;
    idxNext   = idx;
    eqNext    = AeqB;
    gtNext    = AgtB;
    ltNext    = AltB;
    ncmpNext  = ncmp;
    case (state)
      IDLE: begin
        if (start) begin
          raNext = A;
          rbNext = B;
          // Offset-binary: flipping the sign bit maps signed order onto unsigned.
          raNext[WIDTH-1] = A[WIDTH-1] ^ signed_mode;
          rbNext[WIDTH-1] = B[WIDTH-1] ^ signed_mode;
          idxNext   = IW'(NSLICE - 1);
          eqNext    = 1'b0;
          gtNext    = 1'b0;
          ltNext    = 1'b0;
          stateNext = SCAN;
        end
      end
      SCAN: begin
        if (sliceGt || sliceLt || (idx == '0)) begin
          gtNext    = sliceGt;
          ltNext    = sliceLt;
          eqNext    = !sliceGt && !sliceLt;
          ncmpNext  = CW'(NSLICE) - CW'(idx);
          stateNext = DONE;
        end else begin
          idxNext = idx - 1'b1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // Outputs are registered from the next state so they align with it.
    busyNext = (stateNext != IDLE);
    doneNext = (stateNext == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      AeqB  <= 1'b0;
      AgtB  <= 1'b0;
      AltB  <= 1'b0;
      ncmp  <= '0;
    end else begin
      state <= stateNext;
      ra    <= raNext;
      rb    <= rbNext;
      idx   <= idxNext;
      busy  <= busyNext;
      done  <= doneNext;
      AeqB  <= eqNext;
      AgtB  <= gtNext;
      AltB  <= ltNext;
      ncmp  <= ncmpNext;
    end
  end

endmodule

// File: tb/tb_mag_comp_serial.sv
module tb_mag_comp_serial;

  logic        clk = 1'b0;
  logic        rst, start, signed_mode;
  logic [31:0] A, B;
  logic        busy, done, AeqB, AgtB, AltB;
  logic [3:0]  ncmp;

  int passCnt  = 0;
  int totalCnt = 0;

  mag_comp_serial #(.WIDTH(32), .SLICE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .AeqB        (AeqB),
    .AgtB        (AgtB),
    .AltB        (AltB),
    .ncmp        (ncmp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic        eq;
    logic        gt;
    logic        lt;
    int          n;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Called in an idle cycle (cycle 0); returns in the cycle after done.
  task automatic runAndCheck(input string nm, input logic [31:0] a, input logic [31:0] b,
                             input logic sm, input logic eq, input logic gt, input logic lt,
                             input int n, input int lat);
    int cyc;
    bit seen;
    bit busyOk;
    A = a; B = b; signed_mode = sm; start = 1'b1;
    tick();
    start = 1'b0;
    A = $urandom; B = $urandom; signed_mode = ~sm;
    cyc = 1; seen = 0; busyOk = 1;
    chk({nm, "_cleared"}, {29'd0, AeqB, AgtB, AltB}, 32'd0);
    while (cyc < 40 && !seen) begin
      if (!busy) busyOk = 0;
      if (done) seen = 1;
      else begin
        tick();
        cyc++;
      end
    end
    chk({nm, "_latency"}, seen ? cyc : -1, lat);
    chk({nm, "_busy"}, {31'd0, busyOk}, 32'd1);
    chk({nm, "_flags"}, {29'd0, AeqB, AgtB, AltB}, {29'd0, eq, gt, lt});
    chk({nm, "_ncmp"}, {28'd0, ncmp}, n);
    tick();
    chk({nm, "_idle"}, {30'd0, done, busy}, 32'd0);
    chk({nm, "_held"}, {29'd0, AeqB, AgtB, AltB}, {29'd0, eq, gt, lt});
  endtask

  initial begin
    int doneCnt, doneCyc, lastCyc, pulses;
    bit intervalOk;
    bit resResult;
    logic [2:0] flagsAtDone;
    logic [3:0] ncmpAtDone;

    //               a             b             sm    eq    gt    lt    n  lat
    vecs[0] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2};
    vecs[1] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 8, 9};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1, 2};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2};
    vecs[4] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b1, 8, 9};
    vecs[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 8, 9};
    vecs[7] = '{32'h0010_0000, 32'h0020_0000, 1'b0, 1'b0, 1'b0, 1'b1, 3, 4};
    vecs[8] = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 1'b1, 8, 9};
    vecs[9] = '{32'h0000_0010, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 7, 8};

    // Reset, with start asserted to confirm reset dominates.
    rst = 1'b1; start = 1'b1; signed_mode = 1'b0; A = 32'h1; B = 32'h0;
    tick();
    tick();
    chk("reset_outputs", {26'd0, busy, done, AeqB, AgtB, AltB, 1'b0} | {28'd0, ncmp}, 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("reset_idle", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 10; i++)
      runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm,
                  vecs[i].eq, vecs[i].gt, vecs[i].lt, vecs[i].n, vecs[i].lat);

    // start while busy is ignored.
    A = 32'd5; B = 32'd9; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    A = 32'd9; B = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    doneCnt = 0; doneCyc = -1; flagsAtDone = '0; ncmpAtDone = '0;
    for (int c = 4; c <= 16; c++) begin
      if (done) begin
        doneCnt++;
        if (doneCyc < 0) begin
          doneCyc = c;
          flagsAtDone = {AeqB, AgtB, AltB};
          ncmpAtDone = ncmp;
        end
      end
      tick();
    end
    chk("busy_start_pulses", doneCnt, 1);
    chk("busy_start_cycle", doneCyc, 9);
    chk("busy_start_flags", {29'd0, flagsAtDone}, 32'd1);
    chk("busy_start_ncmp", {28'd0, ncmpAtDone}, 32'd8);

    // Back-to-back throughput with start held high, m = 1.
    A = 32'h8000_0000; B = 32'h0; signed_mode = 1'b0; start = 1'b1;
    pulses = 0; lastCyc = -1; intervalOk = 1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) begin
        pulses++;
        if (lastCyc < 0) chk("thru_first", c, 2);
        else if (c - lastCyc != 3) intervalOk = 0;
        lastCyc = c;
      end
    end
    start = 1'b0;
    chk("thru_pulses", pulses, 7);
    chk("thru_interval", {31'd0, intervalOk}, 32'd1);
    chk("thru_flags", {29'd0, AeqB, AgtB, AltB}, 32'd2);
    for (int c = 0; c < 20 && busy; c++) tick();
    chk("thru_drain", {31'd0, busy}, 32'd0);

    // Reset in the third SCAN cycle aborts without a done pulse.
    A = 32'hCAFE_BABE; B = 32'hCAFE_BABE; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    resResult = 0;
    if (done) resResult = 1;
    tick();
    if (done) resResult = 1;
    tick();
    if (done) resResult = 1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outputs", {27'd0, busy, done, AeqB, AgtB, AltB}, 32'd0);
    chk("abort_ncmp", {28'd0, ncmp}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) resResult = 1;
    end
    chk("abort_no_done", {31'd0, resResult}, 32'd0);
    runAndCheck("after_abort", 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8, 9);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mag_comp_serial.md
Name: mag_comp_serial

Overview:
Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands. It supports unsigned or two's-complement signed comparison, selected per operation. Operands are captured on a start handshake and scanned MSB-first, SLICE bits per clock. The scan terminates early at the first differing slice. Intended for wide-operand datapaths where a single-cycle WIDTH-bit compare would limit Fmax; successor to the 16-bit single-cycle comparator.

Parameters:
WIDTH, 32, operand width in bits; must be a positive multiple of SLICE.
SLICE, 4, bits compared per clock; NSLICE = WIDTH/SLICE.
CW, $clog2(NSLICE+1), width of the ncmp output (localparam, derived; not overridable).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request a comparison; accepted only in IDLE.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
A  input  WIDTH  operand A; sampled with start.
B  input  WIDTH  operand B; sampled with start.
busy  output  1  high in SCAN and DONE.
done  output  1  one-cycle pulse; results valid in this cycle and held afterwards.
AeqB  output  1  A == B.
AgtB  output  1  A > B.
AltB  output  1  A < B.
ncmp  output  CW  number of slices examined in the last operation (1..NSLICE).

Behaviour:
- One clock domain (clk); reset is synchronous and active-high on rst.
- All outputs are registered.
- Reset: state IDLE; busy, done, AeqB, AgtB, AltB = 0; ncmp = 0; operand registers = 0.
- Reset dominates every other input in the same cycle.
- FSM states: IDLE, SCAN, DONE.
- IDLE, start=1: capture A and B into ra and rb.
  - If signed_mode=1, invert bit WIDTH-1 of both captured operands (offset-binary), so that an unsigned compare gives the signed order.
  - Set idx = NSLICE-1. Clear AeqB/AgtB/AltB to 0. Go to SCAN.
- IDLE, start=0: hold state; results stay at their previous values.
- SCAN, each cycle: compare slice ra[idx*SLICE +: SLICE] against rb[same].
  - Slice A > slice B: AgtB=1, go to DONE.
  - Slice A < slice B: AltB=1, go to DONE.
  - Slices equal and idx==0: AeqB=1, go to DONE.
  - Slices equal and idx>0: idx = idx-1, stay in SCAN.
  - On every transition into DONE: ncmp = NSLICE - idx.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Exactly one of AeqB/AgtB/AltB is 1 from done onward. All three are 0 between start acceptance and done.
- Latency: start sampled in cycle 0; m = number of slices examined; done high in cycle m+1.
  - Best case m=1 gives done in cycle 2; equal operands give done in cycle NSLICE+1.
- Throughput: with start held high, a new operation is accepted every m+2 cycles (the IDLE cycle accepts it).
- start while busy: ignored; no queueing; operands and signed_mode are not re-sampled.
- Changes on A, B or signed_mode after acceptance have no effect.
- rst during SCAN or DONE: abort immediately; done is not pulsed; all outputs go to reset values.
- NSLICE=1 is legal: SCAN lasts one cycle and done is high in cycle 2.
- Elaboration-time check: stop with an error if WIDTH % SLICE != 0.

Decomposition:
- Package mag_comp_pkg holds:
  - the state encoding localparams: IDLE=2'd0, SCAN=2'd1, DONE=2'd2;
  - a function computing ceil log2 for CW.
- One sub-module, mag_slice_cmp: purely combinational. Parameter SLICE; inputs a and b [SLICE-1:0]; outputs gt and lt (eq implied when both are 0). It is instantiated once, and its inputs are muxed by idx.

Test Plan:
All cases use WIDTH=32, SLICE=4 (NSLICE=8).
1. Unsigned, A=0x8000_0000, B=0x7FFF_FFFF -> done in cycle 2; AgtB=1, AeqB=AltB=0, ncmp=1.
2. Unsigned, A=B=0x1234_5678 -> done in cycle 9; AeqB=1, ncmp=8; busy high in cycles 1..9.
3. A=0xFFFF_FFFF, B=0x0000_0001:
   - signed_mode=1 -> AltB=1, ncmp=1.
   - signed_mode=0 (repeat) -> AgtB=1, ncmp=1.
4. Unsigned, A=0x0000_0003, B=0x0000_0005 (differ only in the LSB slice) -> AltB=1, ncmp=8, done in cycle 9.
5. Start with A=5, B=9. Pulse start with A=9, B=5 during SCAN.
   - Required: result AltB=1 and only one done pulse.
   - Then hold start high with constant operands: done pulses every m+2 cycles.
6. Assert rst in the 3rd SCAN cycle of an equal-operand compare -> no done pulse; all outputs 0 next cycle. A following start with A=1, B=0 -> AgtB=1, ncmp=8.
